// File: rtl/smart_ram.sv
// smart_ram: audio delay-line controller. A ring buffer of 2^RING_AW bytes
// sits at the bottom of an asynchronous 16-bit SRAM. Clients read or write
// one sample at a byte offset behind a head pointer that moves by one sample
// per advance strobe. Every access takes a fixed 3-cycle SRAM sequence.
// One request of each type can wait while another access is in flight.
module smart_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int RING_AW    = 14,
  parameter int MEM_AW     = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_finish,
  output logic                  write_finish,
  output logic                  busy,
  output logic [MEM_AW-1:0]     SRAM_ADDR,
  inout  wire  [DATA_WIDTH-1:0] SRAM_DQ,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_UB_N,
  output logic                  SRAM_LB_N
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_HOLD, FINISH
  } state_t;

  // The subtraction is done wide enough for both operands, then reduced
  // modulo the ring size.
  localparam int XW = (ADDR_WIDTH > RING_AW) ? ADDR_WIDTH : RING_AW;

  state_t                state_q, state_d;
  logic [RING_AW-1:0]    head_q, head_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [RING_AW-1:0]    rd_pend_addr_q, rd_pend_addr_d;
  logic [RING_AW-1:0]    wr_pend_addr_q, wr_pend_addr_d;
  logic [DATA_WIDTH-1:0] wr_pend_data_q, wr_pend_data_d;
  logic [RING_AW-1:0]    acc_addr_q, acc_addr_d;
  logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  read_finish_q, read_finish_d;
  logic                  write_finish_q, write_finish_d;

  logic [ADDR_WIDTH-1:0] off_even;
  logic [XW-1:0]         diff_x;
  logic [RING_AW-1:0]    req_addr;
  logic                  dq_oe;

  // Samples are 16-bit, so the offset is rounded down to a whole sample.
  assign off_even = {offset[ADDR_WIDTH-1:1], 1'b0};
  assign diff_x   = XW'(head_q) - XW'(off_even);
  assign req_addr = diff_x[RING_AW-1:0];

  // Byte-address LSB is always zero after rounding; the SRAM uses word addresses.
  logic unused_lsbs;
  assign unused_lsbs = offset[0] ^ acc_addr_q[0];

  // Next-state, request capture and pending-slot bookkeeping.
  // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    head_d         = advance ? head_q + RING_AW'(2) : head_q;
    rd_pend_d      = rd_pend_q;
    wr_pend_d      = wr_pend_q;
    rd_pend_addr_d = rd_pend_addr_q;
    wr_pend_addr_d = wr_pend_addr_q;
    wr_pend_data_d = wr_pend_data_q;
    acc_addr_d     = acc_addr_q;
    acc_data_d     = acc_data_q;
    data_out_d     = data_out_q;
    read_finish_d  = 1'b0;
    write_finish_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_pend_q || rd) begin
          state_d = RD_SETUP;
          if (rd_pend_q) begin
            // Serve the waiting read; a new read takes the freed slot.
            acc_addr_d = rd_pend_addr_q;
            rd_pend_d  = rd;
            if (rd) rd_pend_addr_d = req_addr;
          end else begin
            acc_addr_d = req_addr;
          end
          if (wr && !wr_pend_q) begin
            wr_pend_d      = 1'b1;
            wr_pend_addr_d = req_addr;
            wr_pend_data_d = data_in;
          end
        end else if (wr_pend_q || wr) begin
          state_d = WR_SETUP;
          if (wr_pend_q) begin
            acc_addr_d = wr_pend_addr_q;
            acc_data_d = wr_pend_data_q;
            wr_pend_d  = wr;
            if (wr) begin
              wr_pend_addr_d = req_addr;
              wr_pend_data_d = data_in;
            end
          end else begin
            acc_addr_d = req_addr;
            acc_data_d = data_in;
          end
        end
      end
      RD_SETUP:  state_d = RD_SAMPLE;
      RD_SAMPLE: begin
        data_out_d    = SRAM_DQ;
        read_finish_d = 1'b1;
        state_d       = FINISH;
      end
      WR_SETUP:  state_d = WR_HOLD;
      WR_HOLD: begin
        write_finish_d = 1'b1;
        state_d        = FINISH;
      end
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Requests arriving mid-access wait in a one-deep slot per type;
    // a duplicate while the slot is full is dropped.
    if (state_q != IDLE) begin
      if (rd && !rd_pend_q) begin
        rd_pend_d      = 1'b1;
        rd_pend_addr_d = req_addr;
      end
      if (wr && !wr_pend_q) begin
        wr_pend_d      = 1'b1;
        wr_pend_addr_d = req_addr;
        wr_pend_data_d = data_in;
      end
    end
  end

  // State register; reset aborts any access in flight.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      head_q         <= '0;
      rd_pend_q      <= 1'b0;
      wr_pend_q      <= 1'b0;
      rd_pend_addr_q <= '0;
      wr_pend_addr_q <= '0;
      wr_pend_data_q <= '0;
      acc_addr_q     <= '0;
      acc_data_q     <= '0;
      data_out_q     <= '0;
      read_finish_q  <= 1'b0;
      write_finish_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      rd_pend_q      <= rd_pend_d;
      wr_pend_q      <= wr_pend_d;
      rd_pend_addr_q <= rd_pend_addr_d;
      wr_pend_addr_q <= wr_pend_addr_d;
      wr_pend_data_q <= wr_pend_data_d;
      acc_addr_q     <= acc_addr_d;
      acc_data_q     <= acc_data_d;
      data_out_q     <= data_out_d;
      read_finish_q  <= read_finish_d;
      write_finish_q <= write_finish_d;
    end
  end

  // SRAM strobes decoded from the state. OE stays low through RD_SAMPLE
  // so the data is still on the bus when it is registered.
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    case (state_q)
      RD_SETUP, RD_SAMPLE: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
      end
      default: ;
    endcase
  end

  assign SRAM_UB_N    = SRAM_CE_N;
  assign SRAM_LB_N    = SRAM_CE_N;
  assign SRAM_DQ      = dq_oe ? acc_data_q : {DATA_WIDTH{1'bz}};
  assign SRAM_ADDR    = MEM_AW'(acc_addr_q[RING_AW-1:1]);
  assign data_out     = data_out_q;
  assign read_finish  = read_finish_q;
  assign write_finish = write_finish_q;
  assign busy         = (state_q != IDLE) || rd_pend_q || wr_pend_q;

endmodule

// File: tb/tb_smart_ram.sv
// tb_smart_ram: directed and random transactions against a behavioural
// SRAM and a reference model (head pointer, ring address arithmetic and
// expected memory contents).
module tb_smart_ram;

  localparam int DW     = 16;
  localparam int AW     = 12;
  localparam int RAW    = 14;
  localparam int MAW    = 18;
  localparam int NWORDS = 1 << (RAW - 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           advance, rd, wr;
  logic [AW-1:0]  offset;
  logic [DW-1:0]  data_in;
  logic [DW-1:0]  data_out;
  logic           read_finish, write_finish, busy;
  logic [MAW-1:0] sram_addr;
  wire  [DW-1:0]  sram_dq;
  logic           ce_n, oe_n, we_n, ub_n, lb_n;

  smart_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RING_AW(RAW), .MEM_AW(MAW)) dut (
    .clk(clk), .rst(rst), .advance(advance), .rd(rd), .wr(wr),
    .offset(offset), .data_in(data_in), .data_out(data_out),
    .read_finish(read_finish), .write_finish(write_finish), .busy(busy),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural asynchronous SRAM.
  logic [DW-1:0] sram_mem [NWORDS];
  logic [DW-1:0] ref_mem  [NWORDS];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[RAW-2:0]] : 'z;
  always @(negedge clk) if (!ce_n && !we_n) sram_mem[sram_addr[RAW-2:0]] <= sram_dq;

  // Bus monitor.
  int rf_q[$], rdata_q[$], wf_q[$], we_addr_q[$], we_dq_q[$], oe_addr_q[$];
  int proto_err = 0;
  always @(negedge clk) begin
    if (read_finish)  begin rf_q.push_back(cyc); rdata_q.push_back(int'(data_out)); end
    if (write_finish) wf_q.push_back(cyc);
    if (!we_n) begin we_addr_q.push_back(int'(sram_addr)); we_dq_q.push_back(int'(sram_dq)); end
    if (!oe_n) oe_addr_q.push_back(int'(sram_addr));
    if (!oe_n && !we_n) proto_err++;
    if (ub_n != ce_n || lb_n != ce_n) proto_err++;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Reference model: head counts samples; address is head minus even offset, modulo ring.
  logic [RAW-1:0] model_head;

  function automatic int exp_word(input logic [RAW-1:0] h, input logic [AW-1:0] off);
    int v;
    v = int'(h) - (int'(off) / 2) * 2;
    if (v < 0) v += (1 << RAW);
    return v / 2;
  endfunction

  task automatic clear_mon();
    rf_q.delete(); rdata_q.delete(); wf_q.delete();
    we_addr_q.delete(); we_dq_q.delete(); oe_addr_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    if (advance) model_head = model_head + RAW'(2);
    #1;
  endtask

  task automatic adv_n(input int n);
    advance = 1'b1;
    repeat (n) tick();
    advance = 1'b0;
  endtask

  task automatic do_reset();
    rd = 1'b0; wr = 1'b0; advance = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_data_out", int'(data_out), 0);
    check("rst_pulses_busy", int'({read_finish, write_finish, busy}), 0);
    check("rst_sram_addr", int'(sram_addr), 0);
    check("rst_strobes", int'({ce_n, oe_n, we_n, ub_n, lb_n}), 5'b11111);
    tick();
    tick();
    rst = 1'b1;
    model_head = '0;
    tick();
  endtask

  // One transaction (rd, wr or both in the same cycle) followed by a fixed window.
  task automatic op(input bit r, input bit w, input logic [AW-1:0] off,
                    input logic [DW-1:0] din, input bit adv_rand, output int word);
    int c_req;
    clear_mon();
    word  = exp_word(model_head, off);
    c_req = cyc;
    rd = r; wr = w; offset = off; data_in = din;
    advance = adv_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    rd = 1'b0; wr = 1'b0;
    offset = AW'($urandom); data_in = DW'($urandom);
    repeat (10) begin
      advance = adv_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    advance = 1'b0;
    if (r) begin
      check("rd_pulses", rf_q.size(), 1);
      check("rd_cycle", at(rf_q, 0), c_req + 3);
      check("rd_data", at(rdata_q, 0), int'(ref_mem[word]));
      check("rd_oe_cycles", oe_addr_q.size(), 2);
      check("rd_addr", at(oe_addr_q, 0), word);
    end
    if (w) begin
      check("wr_pulses", wf_q.size(), 1);
      check("wr_cycle", at(wf_q, 0), c_req + (r ? 7 : 3));
      check("wr_we_cycles", we_addr_q.size(), 2);
      check("wr_addr", at(we_addr_q, 0), word);
      check("wr_dq", at(we_dq_q, 0), int'(din));
      ref_mem[word] = din;
    end
    check("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int w, w1, w2, c0;
    logic [AW-1:0] o1, o2, o3;

    for (int i = 0; i < NWORDS; i++) begin
      sram_mem[i] = DW'((i * 37) ^ 16'hA5A5);
      ref_mem[i]  = DW'((i * 37) ^ 16'hA5A5);
    end
    rst = 1'b0; advance = 1'b0; rd = 1'b0; wr = 1'b0; offset = '0; data_in = '0;
    model_head = '0;
    @(posedge clk); #1;
    do_reset();

    // Write behind the head after four samples, then read it back two samples later.
    adv_n(4);
    op(1'b0, 1'b1, 12'd0, 16'h1234, 1'b0, w);
    check("wr_word4", at(we_addr_q, 0), 4);
    adv_n(2);
    op(1'b1, 1'b0, 12'd4, 16'h0000, 1'b0, w);
    check("rd_word4", at(oe_addr_q, 0), 4);
    check("rd_1234", at(rdata_q, 0), 16'h1234);

    // Simultaneous read and write: read first, write four cycles later.
    op(1'b1, 1'b1, 12'd10, 16'hBEEF, 1'b0, w);
    check("both_order", at(wf_q, 0) - at(rf_q, 0), 4);

    // Wrap below zero; odd offset rounds down to the same sample.
    do_reset();
    op(1'b1, 1'b0, 12'd2, 16'h0000, 1'b0, w);
    check("wrap_off2", at(oe_addr_q, 0), NWORDS - 1);
    op(1'b1, 1'b0, 12'd3, 16'h0000, 1'b0, w);
    check("wrap_off3", at(oe_addr_q, 0), NWORDS - 1);

    // Two reads queued behind an active one: the third is dropped.
    adv_n(7);
    clear_mon();
    o1 = 12'd6; o2 = 12'd40; o3 = 12'd100;
    w1 = exp_word(model_head, o1);
    w2 = exp_word(model_head, o2);
    c0 = cyc;
    rd = 1'b1; offset = o1; tick();
    offset = o2; tick();
    check("busy_active", int'(busy), 1);
    offset = o3; tick();
    rd = 1'b0;
    repeat (12) tick();
    check("pend_pulses", rf_q.size(), 2);
    check("pend_cycle0", at(rf_q, 0), c0 + 3);
    check("pend_cycle1", at(rf_q, 1), c0 + 7);
    check("pend_data0", at(rdata_q, 0), int'(ref_mem[w1]));
    check("pend_data1", at(rdata_q, 1), int'(ref_mem[w2]));

    // Reset asserted during WR_HOLD aborts the write with no finish pulse.
    clear_mon();
    w = exp_word(model_head, 12'd20);
    wr = 1'b1; offset = 12'd20; data_in = 16'h5A5A; tick();
    wr = 1'b0; tick();
    check("hold_we_low", int'(we_n), 0);
    #2 rst = 1'b0;
    #1;
    check("abort_strobes", int'({ce_n, oe_n, we_n, ub_n, lb_n}), 5'b11111);
    check("abort_busy", int'(busy), 0);
    tick(); tick();
    rst = 1'b1;
    model_head = '0;
    repeat (6) tick();
    check("abort_no_finish", wf_q.size(), 0);
    ref_mem[w] = sram_mem[w]; // aborted write leaves this word undefined

    // Random traffic with advances during accesses.
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      adv_n($urandom_range(0, 3));
      op(kind == 0 || kind == 2, kind != 0, AW'($urandom), DW'($urandom), 1'b1, w);
    end

    check("protocol", proto_err, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
